regfile_sb: RTL and testbench



---
 rtl/regfile_sb_pkg.sv | 15 +
 rtl/regfile_busy_table.sv | 43 ++++
 rtl/regfile_sb.sv | 138 +++++++++++++
 tb/tb_regfile_sb.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared types and default constants for the regfile_sb register file.
// FSM state encoding plus the parameter defaults used by the top and its bench.
package regfile_sb_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int          DEF_WIDTH    = 32;
    localparam int          DEF_DEPTH    = 32;
    localparam int          DEF_SP_INDEX = 29;
    localparam logic [31:0] DEF_SP_INIT  = 32'h3ffc;

endpackage

// File: rtl/regfile_busy_table.sv
// Per-register busy scoreboard: one bit per register, set by reserve, cleared by write.
// Register 0 is never marked busy; a same-edge set and clear leaves the bit set.
module regfile_busy_table #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic              o_busy1,
    output logic              o_busy2
);

    logic [DEPTH-1:0] r_busy;
    logic             w_set_ok;
    logic             w_clr_ok;

    assign w_set_ok = i_set_en && (i_set_addr != '0);
    assign w_clr_ok = i_clr_en && (i_clr_addr != '0);

    // Set is applied after clear so a reservation on the write edge survives.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            if (w_clr_ok) begin
                r_busy[i_clr_addr] <= 1'b0;
            end
            if (w_set_ok) begin
                r_busy[i_set_addr] <= 1'b1;
            end
        end
    end

    assign o_busy1 = (i_rd_addr1 != '0) && r_busy[i_rd_addr1];
    assign o_busy2 = (i_rd_addr2 != '0) && r_busy[i_rd_addr2];

endmodule

// File: rtl/regfile_sb.sv
// Register file with two async read ports, one write port, post-reset clear sweep and busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int          WIDTH    = DEF_WIDTH,
    parameter int          DEPTH    = DEF_DEPTH,
    parameter int          ADDR_W   = $clog2(DEPTH),
    parameter int          SP_INDEX = DEF_SP_INDEX,
    parameter logic [31:0] SP_INIT  = DEF_SP_INIT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveRegister,
    output logic              Ready
);

    localparam logic [WIDTH-1:0]  SP_INIT_W = WIDTH'(SP_INIT);
    localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(SP_INDEX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_run;
    logic              w_sweep_last;
    logic [WIDTH-1:0]  w_sweep_data;
    logic              w_wr_en;
    logic              w_rsv_en;
    logic              w_tbl_busy1;
    logic              w_tbl_busy2;

    assign w_run        = (r_state == ST_RUN);
    assign w_sweep_last = (r_ptr == LAST_ADDR);
    assign w_sweep_data = (r_ptr == SP_ADDR) ? SP_INIT_W : '0;
    assign w_wr_en      = w_run && RegWrite && (WriteRegister != '0);
    assign w_rsv_en     = w_run && Reserve && (ReserveRegister != '0);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= ADDR_W'(1);
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR) begin
                r_ptr <= r_ptr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        Ready        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (w_sweep_last) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                Ready = 1'b1;
            end
            default: begin
                w_state_next = ST_CLEAR;
            end
        endcase
    end

    // Storage has no reset of its own; the sweep initialises it and a reset edge leaves it alone.
    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_ptr] <= w_sweep_data;
            end else if (w_wr_en) begin
                r_mem[WriteRegister] <= WriteData;
            end
        end
    end

    regfile_busy_table #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_busy (
        .i_clk      (Clk),
        .i_rst_n    (Rst_n),
        .i_set_en   (w_rsv_en && Rst_n),
        .i_set_addr (ReserveRegister),
        .i_clr_en   (w_wr_en && Rst_n),
        .i_clr_addr (WriteRegister),
        .i_rd_addr1 (ReadRegister1),
        .i_rd_addr2 (ReadRegister2),
        .o_busy1    (w_tbl_busy1),
        .o_busy2    (w_tbl_busy2)
    );

    always_comb begin
        ReadData1 = '0;
        Busy1     = 1'b0;
        if (w_run && (ReadRegister1 != '0)) begin
            ReadData1 = r_mem[ReadRegister1];
            Busy1     = w_tbl_busy1;
`ifdef REGFILE_SB_BYPASS_EN
            if (w_wr_en && (WriteRegister == ReadRegister1)) begin
                ReadData1 = WriteData;
                Busy1     = w_rsv_en && (ReserveRegister == ReadRegister1);
            end
`endif
        end
    end

    always_comb begin
        ReadData2 = '0;
        Busy2     = 1'b0;
        if (w_run && (ReadRegister2 != '0)) begin
            ReadData2 = r_mem[ReadRegister2];
            Busy2     = w_tbl_busy2;
`ifdef REGFILE_SB_BYPASS_EN
            if (w_wr_en && (WriteRegister == ReadRegister2)) begin
                ReadData2 = WriteData;
                Busy2     = w_rsv_en && (ReserveRegister == ReadRegister2);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: sweep, write/read, busy tracking, reset and bypass behaviour.
// Read expectations are queued as each read is set up and popped once the outputs settle.
module tb_regfile_sb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic [AW-1:0] ReadRegister1, ReadRegister2, WriteRegister, ReserveRegister;
    logic [DW-1:0] ReadData1, ReadData2, WriteData;
    logic          Busy1, Busy2, RegWrite, Reserve, Ready;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string         tag;
        logic [DW-1:0] d1;
        logic          b1;
        logic [DW-1:0] d2;
        logic          b2;
    } exp_t;

    exp_t sb[$];

    regfile_sb dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .ReadRegister1   (ReadRegister1),
        .ReadRegister2   (ReadRegister2),
        .ReadData1       (ReadData1),
        .ReadData2       (ReadData2),
        .Busy1           (Busy1),
        .Busy2           (Busy2),
        .WriteRegister   (WriteRegister),
        .WriteData       (WriteData),
        .RegWrite        (RegWrite),
        .Reserve         (Reserve),
        .ReserveRegister (ReserveRegister),
        .Ready           (Ready)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", tag, obs, exp);
    endtask

    // Advance one edge and land 2 time units after it, away from both clock edges.
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic [DW-1:0] d1, input logic b1,
                      input logic [DW-1:0] d2, input logic b2);
        exp_t e;
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        sb.push_back('{tag, d1, b1, d2, b2});
        #1;
        e = sb.pop_front();
        chk({e.tag, ".d1"}, ReadData1, e.d1);
        chk({e.tag, ".b1"}, {31'd0, Busy1}, {31'd0, e.b1});
        chk({e.tag, ".d2"}, ReadData2, e.d2);
        chk({e.tag, ".b2"}, {31'd0, Busy2}, {31'd0, e.b2});
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rsv, input logic [AW-1:0] ra);
        RegWrite        = 1'b1;
        WriteRegister   = a;
        WriteData       = d;
        Reserve         = rsv;
        ReserveRegister = ra;
        tick();
        RegWrite = 1'b0;
        Reserve  = 1'b0;
    endtask

    task automatic reserve(input logic [AW-1:0] ra);
        Reserve         = 1'b1;
        ReserveRegister = ra;
        tick();
        Reserve = 1'b0;
    endtask

    // Counts the sweep edges after release; Ready must be low until edge 31.
    task automatic sweep(input string tag);
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk($sformatf("%s.ready_e%0d", tag, i), {31'd0, Ready}, (i == 31) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        WriteRegister = '0; WriteData = '0; RegWrite = 1'b0;
        Reserve = 1'b0; ReserveRegister = '0;

        tick();
        tick();
        chk("rst.ready", {31'd0, Ready}, 32'd0);
        rd("rst.rd", 5'd29, 5'd7, 32'd0, 1'b0, 32'd0, 1'b0);

        // Release reset while driving a write and a reserve that the sweep must ignore.
        Rst_n           = 1'b1;
        RegWrite        = 1'b1;
        WriteRegister   = 5'd9;
        WriteData       = 32'hff;
        Reserve         = 1'b1;
        ReserveRegister = 5'd9;
        sweep("sweep");
        RegWrite = 1'b0;
        Reserve  = 1'b0;

        rd("sweep.sp", 5'd29, 5'd5, 32'h3ffc, 1'b0, 32'd0, 1'b0);
        rd("sweep.hi", 5'd31, 5'd9, 32'd0, 1'b0, 32'd0, 1'b0);

        wr(5'd7, 32'hdeadbeef, 1'b0, 5'd0);
        rd("wr7", 5'd7, 5'd0, 32'hdeadbeef, 1'b0, 32'd0, 1'b0);
        wr(5'd0, 32'h1, 1'b0, 5'd0);
        rd("wr0", 5'd0, 5'd7, 32'd0, 1'b0, 32'hdeadbeef, 1'b0);

        reserve(5'd3);
        rd("rsv3", 5'd3, 5'd7, 32'd0, 1'b1, 32'hdeadbeef, 1'b0);
        wr(5'd3, 32'h55, 1'b0, 5'd0);
        rd("wr3", 5'd3, 5'd29, 32'h55, 1'b0, 32'h3ffc, 1'b0);
        wr(5'd4, 32'h66, 1'b1, 5'd4);
        rd("rsvwr4", 5'd4, 5'd3, 32'h66, 1'b1, 32'h55, 1'b0);
        wr(5'd8, 32'h1234, 1'b0, 5'd0);
        reserve(5'd0);
        rd("nb8_r0", 5'd8, 5'd0, 32'h1234, 1'b0, 32'd0, 1'b0);

        // Mid-operation reset drops the reservation and re-clears storage.
        wr(5'd11, 32'h77, 1'b1, 5'd10);
        rd("pre_rst", 5'd10, 5'd11, 32'd0, 1'b1, 32'h77, 1'b0);
        Rst_n = 1'b0;
        tick();
        chk("midrst.ready", {31'd0, Ready}, 32'd0);
        rd("midrst.rd", 5'd10, 5'd11, 32'd0, 1'b0, 32'd0, 1'b0);
        Rst_n = 1'b1;
        sweep("resweep");
        rd("resweep.rd", 5'd10, 5'd11, 32'd0, 1'b0, 32'd0, 1'b0);
        rd("resweep.keep", 5'd7, 5'd29, 32'd0, 1'b0, 32'h3ffc, 1'b0);

        // Same-cycle forwarding of a write to a read port.
        RegWrite      = 1'b1;
        WriteRegister = 5'd12;
        WriteData     = 32'haa;
`ifdef REGFILE_SB_BYPASS_EN
        rd("byp.same", 5'd12, 5'd29, 32'haa, 1'b0, 32'h3ffc, 1'b0);
`else
        rd("byp.same", 5'd12, 5'd29, 32'd0, 1'b0, 32'h3ffc, 1'b0);
`endif
        tick();
        RegWrite = 1'b0;
        rd("byp.after", 5'd12, 5'd0, 32'haa, 1'b0, 32'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
